ld3320_cmd_seq: RTL and testbench

Command sequencer directly upstream of the LD3320 parallel-bus write/read engine. Walks a script of register operations (write, read, delay, end) stored in a command ROM, issues each write/read to the bus engine through its `ena`/`sel`/`address`/`data` inputs, and waits for `data_ready` before advancing. Used for LD3320 power-up init, ASR keyword loading and result polling; each script is selected by its start index.

---
 rtl/ld3320_pkg.sv | 64 ++++++
 rtl/ld3320_cmd_rom.sv | 24 ++
 rtl/ld3320_cmd_seq.sv | 180 ++++++++++++++++++
 tb/tb_ld3320_cmd_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld3320_pkg.sv
// ld3320_pkg: opcodes, command-entry layout, sequencer states and the
// LD3320 register map shared by the sequencer and the bus engine.
package ld3320_pkg;

   localparam int unsigned ENTRY_W   = 18;
   localparam int unsigned MAX_DEPTH = 256;
   localparam int unsigned IMG_W     = MAX_DEPTH * ENTRY_W;

   localparam int unsigned OP_HI   = 17;
   localparam int unsigned OP_LO   = 16;
   localparam int unsigned ADDR_HI = 15;
   localparam int unsigned ADDR_LO = 8;
   localparam int unsigned DATA_HI = 7;
   localparam int unsigned DATA_LO = 0;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   localparam logic [7:0] REG_FIFO_STAT = 8'h06;
   localparam logic [7:0] REG_SOFT_RST  = 8'h17;
   localparam logic [7:0] REG_ADC_SEL   = 8'h1C;
   localparam logic [7:0] REG_INT_EN    = 8'h29;
   localparam logic [7:0] REG_INT_STAT  = 8'h2B;
   localparam logic [7:0] REG_ADC_GAIN  = 8'h35;
   localparam logic [7:0] REG_ANALOG    = 8'h89;
   localparam logic [7:0] REG_ASR_BUSY  = 8'hB2;
   localparam logic [7:0] REG_ASR_CNT   = 8'hBA;
   localparam logic [7:0] REG_ASR_RES   = 8'hC5;
   localparam logic [7:0] REG_LP_CTRL   = 8'hCF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_WAIT,
      ST_DELAY
   } seq_state_t;

   function automatic logic [ENTRY_W-1:0] mk_entry(
      input logic [1:0] op,
      input logic [7:0] addr,
      input logic [7:0] dat
   );
      return {op, addr, dat};
   endfunction

   // Power-up init script at index 0; every unused entry reads as END.
   function automatic logic [IMG_W-1:0] default_image();
      logic [IMG_W-1:0] img;
      img = '1;
      img[0*ENTRY_W +: ENTRY_W] = mk_entry(OP_WRITE, REG_SOFT_RST, 8'h35);
      img[1*ENTRY_W +: ENTRY_W] = mk_entry(OP_DELAY, 8'h00, 8'd10);
      img[2*ENTRY_W +: ENTRY_W] = mk_entry(OP_WRITE, REG_ANALOG, 8'h03);
      img[3*ENTRY_W +: ENTRY_W] = mk_entry(OP_DELAY, 8'h00, 8'd5);
      img[4*ENTRY_W +: ENTRY_W] = mk_entry(OP_WRITE, REG_LP_CTRL, 8'h43);
      img[5*ENTRY_W +: ENTRY_W] = mk_entry(OP_WRITE, REG_INT_EN, 8'h10);
      img[6*ENTRY_W +: ENTRY_W] = mk_entry(OP_READ, REG_FIFO_STAT, 8'h00);
      img[7*ENTRY_W +: ENTRY_W] = mk_entry(OP_END, 8'h00, 8'h00);
      return img;
   endfunction

endpackage

// File: rtl/ld3320_cmd_rom.sv
// ld3320_cmd_rom: registered command ROM; contents come from a flat image
// parameter so each build can load its own scripts.
module ld3320_cmd_rom
   import ld3320_pkg::*;
#(
   parameter int unsigned      ROM_DEPTH = 64,
   parameter logic [IMG_W-1:0] ROM_IMAGE = default_image()
) (
   input  logic                         clk,
   input  logic [$clog2(ROM_DEPTH)-1:0] addr,
   output logic [ENTRY_W-1:0]           q
);

   logic [ENTRY_W-1:0] mem [ROM_DEPTH];

   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_ent
      assign mem[i] = ROM_IMAGE[i*ENTRY_W +: ENTRY_W];
   end

   always_ff @(posedge clk) begin
      q <= mem[addr];
   end

endmodule

// File: rtl/ld3320_cmd_seq.sv
// ld3320_cmd_seq: walks a ROM script of write/read/delay/end entries and
// drives the LD3320 bus engine one operation at a time.
module ld3320_cmd_seq
   import ld3320_pkg::*;
#(
   parameter int unsigned      ROM_DEPTH         = 64,
   parameter int unsigned      DELAY_UNIT_CYCLES = 50000,
   parameter int unsigned      TIMEOUT_CYCLES    = 4096,
   parameter logic [IMG_W-1:0] ROM_IMAGE         = default_image()
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(ROM_DEPTH)-1:0] start_idx,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         rd_valid,
   output logic [7:0]                   rd_addr,
   output logic [7:0]                   rd_data,
   output logic                         ena,
   output logic                         sel,
   output logic [7:0]                   address,
   output logic [7:0]                   data,
   input  logic                         data_ready,
   input  logic [7:0]                   data_valid
);

   localparam int unsigned     IW       = $clog2(ROM_DEPTH);
   localparam logic [IW-1:0]   IDX_LAST = IW'(ROM_DEPTH - 1);
   localparam logic [31:0]     TMO_LAST = TIMEOUT_CYCLES - 1;
   localparam logic [31:0]     UNIT     = DELAY_UNIT_CYCLES;

   seq_state_t state_q, state_n;

   logic [IW-1:0]      idx_q, idx_n;
   logic [31:0]        dcnt_q, dcnt_n;
   logic [31:0]        tmr_q, tmr_n;
   logic [ENTRY_W-1:0] rom_q;
   logic [1:0]         ent_op;
   logic [7:0]         ent_addr;
   logic [7:0]         ent_data;
   logic               adv;

   logic       busy_n, done_n, err_n, rdv_n;
   logic       ena_n, sel_n;
   logic [7:0] rda_n, rdd_n, addr_n, wdat_n;

   ld3320_cmd_rom #(
      .ROM_DEPTH(ROM_DEPTH),
      .ROM_IMAGE(ROM_IMAGE)
   ) u_rom (
      .clk (clk),
      .addr(idx_q),
      .q   (rom_q)
   );

   assign ent_op   = rom_q[OP_HI:OP_LO];
   assign ent_addr = rom_q[ADDR_HI:ADDR_LO];
   assign ent_data = rom_q[DATA_HI:DATA_LO];

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      dcnt_n  = dcnt_q;
      tmr_n   = tmr_q;
      adv     = 1'b0;
      // busy drops one cycle after done/err so a start on that cycle is ignored
      busy_n  = busy & ~(done | err);
      done_n  = 1'b0;
      err_n   = 1'b0;
      rdv_n   = 1'b0;
      rda_n   = rd_addr;
      rdd_n   = rd_data;
      ena_n   = ena;
      sel_n   = sel;
      addr_n  = address;
      wdat_n  = data;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !busy) begin
               idx_n   = start_idx;
               busy_n  = 1'b1;
               state_n = ST_FETCH;
            end
         end
         ST_FETCH: state_n = ST_EXEC;
         ST_EXEC: begin
            unique case (ent_op)
               OP_WRITE, OP_READ: begin
                  ena_n   = 1'b1;
                  sel_n   = (ent_op == OP_WRITE);
                  addr_n  = ent_addr;
                  wdat_n  = ent_data;
                  tmr_n   = '0;
                  state_n = ST_WAIT;
               end
               OP_DELAY: begin
                  dcnt_n = {24'd0, ent_data} * UNIT;
                  if (ent_data == 8'd0) adv = 1'b1;
                  else state_n = ST_DELAY;
               end
               OP_END: begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            endcase
         end
         ST_WAIT: begin
            if (data_ready) begin
               ena_n = 1'b0;
               adv   = 1'b1;
               if (!sel) begin
                  rdv_n = 1'b1;
                  rda_n = address;
                  rdd_n = data_valid;
               end
            end else if (tmr_q == TMO_LAST) begin
               ena_n   = 1'b0;
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end else begin
               tmr_n = tmr_q + 32'd1;
            end
         end
         ST_DELAY: begin
            if (dcnt_q <= 32'd1) adv = 1'b1;
            else dcnt_n = dcnt_q - 32'd1;
         end
         default: state_n = ST_IDLE;
      endcase

      // The last ROM entry ends the script; the index never wraps.
      if (adv) begin
         if (idx_q == IDX_LAST) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
         end else begin
            idx_n   = idx_q + 1'b1;
            state_n = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         dcnt_q   <= '0;
         tmr_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         rd_addr  <= 8'h00;
         rd_data  <= 8'h00;
         ena      <= 1'b0;
         sel      <= 1'b1;
         address  <= 8'h00;
         data     <= 8'h00;
      end else begin
         state_q  <= state_n;
         idx_q    <= idx_n;
         dcnt_q   <= dcnt_n;
         tmr_q    <= tmr_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
         rd_valid <= rdv_n;
         rd_addr  <= rda_n;
         rd_data  <= rdd_n;
         ena      <= ena_n;
         sel      <= sel_n;
         address  <= addr_n;
         data     <= wdat_n;
      end
   end

endmodule

// File: tb/tb_ld3320_cmd_seq.sv
// tb_ld3320_cmd_seq: scoreboard bench; a script model predicts bus ops,
// read results and end events with their cycle timing.
module tb_ld3320_cmd_seq;
   import ld3320_pkg::*;

   localparam int DEPTH = 64;
   localparam int DU    = 10;
   localparam int TMO   = 16;

   function automatic logic [IMG_W-1:0] tb_image();
      logic [IMG_W-1:0] img;
      img = '1;
      img[18*0  +: 18] = {OP_WRITE, 8'h17, 8'h35};
      img[18*2  +: 18] = {OP_READ,  8'h06, 8'h00};
      img[18*4  +: 18] = {OP_WRITE, 8'h35, 8'h80};
      img[18*5  +: 18] = {OP_DELAY, 8'h00, 8'd3};
      img[18*6  +: 18] = {OP_WRITE, 8'h1C, 8'h0B};
      img[18*8  +: 18] = {OP_WRITE, 8'h45, 8'hAA};
      img[18*10 +: 18] = {OP_READ,  8'h2B, 8'h00};
      img[18*11 +: 18] = {OP_WRITE, 8'h89, 8'h03};
      img[18*12 +: 18] = {OP_READ,  8'h06, 8'h00};
      img[18*13 +: 18] = {OP_DELAY, 8'h00, 8'd0};
      img[18*14 +: 18] = {OP_READ,  8'hBA, 8'h00};
      img[18*16 +: 18] = {OP_DELAY, 8'h00, 8'd2};
      img[18*60 +: 18] = {OP_WRITE, 8'hC5, 8'h01};
      img[18*61 +: 18] = {OP_WRITE, 8'hCF, 8'h43};
      img[18*62 +: 18] = {OP_WRITE, 8'hB2, 8'hFF};
      img[18*63 +: 18] = {OP_WRITE, 8'h29, 8'h10};
      return img;
   endfunction

   localparam logic [IMG_W-1:0] IMG = tb_image();

   typedef struct {
      logic       sel;
      logic [7:0] addr;
      logic [7:0] dat;
      int         gap;
   } op_t;
   typedef struct {
      logic [7:0] addr;
      logic [7:0] dat;
   } rd_t;
   typedef struct {
      logic is_err;
      int   gap;
   } end_t;

   logic       clk, rst, start;
   logic [5:0] start_idx;
   logic       busy, done, err, rd_valid, ena, sel;
   logic [7:0] rd_addr, rd_data, address, data;
   logic       data_ready;
   logic [7:0] data_valid;

   logic [17:0] tbl [DEPTH];
   op_t         op_q[$];
   rd_t         rd_q[$];
   end_t        end_q[$];
   logic [7:0]  resp_q[$];

   int cyc = 0;
   int ref_cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit hang = 0;
   bit fixed_lat = 0;

   ld3320_cmd_seq #(
      .ROM_DEPTH(DEPTH),
      .DELAY_UNIT_CYCLES(DU),
      .TIMEOUT_CYCLES(TMO),
      .ROM_IMAGE(IMG)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .start_idx(start_idx),
      .busy(busy), .done(done), .err(err),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .ena(ena), .sel(sel), .address(address), .data(data),
      .data_ready(data_ready), .data_valid(data_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Script model: each entry costs FETCH+EXEC, a delay adds n*DU cycles.
   task automatic model(input int s, input bit hng);
      int i, gap;
      bit fin;
      logic [17:0] e;
      op_t o;
      rd_t r;
      end_t t;
      i = s;
      gap = 2;
      fin = 0;
      while (!fin) begin
         e = tbl[i];
         if (e[17:16] == OP_END) begin
            t.is_err = 0;
            t.gap = gap;
            end_q.push_back(t);
            fin = 1;
         end else if (e[17:16] == OP_DELAY) begin
            gap += 2 + int'(e[7:0]) * DU;
         end else begin
            o.sel = (e[17:16] == OP_WRITE);
            o.addr = e[15:8];
            o.dat = e[7:0];
            o.gap = gap;
            op_q.push_back(o);
            gap = 2;
            if (hng) begin
               t.is_err = 1;
               t.gap = TMO;
               end_q.push_back(t);
               fin = 1;
            end else if (!o.sel) begin
               r.addr = e[15:8];
               r.dat = 8'($urandom);
               resp_q.push_back(r.dat);
               rd_q.push_back(r);
            end
         end
         if (!fin) begin
            if (i == DEPTH - 1) begin
               t.is_err = 0;
               t.gap = gap - 2;
               end_q.push_back(t);
               fin = 1;
            end else begin
               i++;
            end
         end
      end
   endtask

   initial begin : engine
      int lat;
      data_ready = 1'b0;
      data_valid = 8'h00;
      forever begin
         @(negedge clk);
         if (ena && !hang && !rst) begin
            lat = fixed_lat ? 5 : int'($urandom_range(2, 6));
            repeat (lat - 1) @(negedge clk);
            chk("ena_held", ena, 1);
            if (!sel && resp_q.size() > 0) data_valid = resp_q.pop_front();
            else data_valid = 8'($urandom);
            data_ready = 1'b1;
            ref_cyc = cyc + 1;
            @(negedge clk);
            data_ready = 1'b0;
            data_valid = 8'($urandom);
         end
      end
   end

   initial begin : monitor
      op_t o;
      rd_t r;
      end_t t;
      int rise_cyc;
      logic ena_prev;
      rise_cyc = 0;
      ena_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ena && !ena_prev) begin
               rise_cyc = cyc;
               chk("op_expected", op_q.size() > 0, 1);
               if (op_q.size() > 0) begin
                  o = op_q.pop_front();
                  chk("op_sel", sel, o.sel);
                  chk("op_addr", address, o.addr);
                  chk("op_data", data, o.dat);
                  chk("op_time", cyc, ref_cyc + o.gap);
               end
            end
            if (rd_valid) begin
               chk("rd_expected", rd_q.size() > 0, 1);
               if (rd_q.size() > 0) begin
                  r = rd_q.pop_front();
                  chk("rd_addr", rd_addr, r.addr);
                  chk("rd_data", rd_data, r.dat);
                  chk("rd_time", cyc, ref_cyc);
                  chk("rd_ena_low", ena, 0);
               end
            end
            if (done || err) begin
               chk("end_expected", end_q.size() > 0, 1);
               if (end_q.size() > 0) begin
                  t = end_q.pop_front();
                  chk("end_kind", {done, err}, t.is_err ? 2'b01 : 2'b10);
                  if (t.is_err) begin
                     chk("err_time", cyc, rise_cyc + t.gap);
                     chk("err_ena_low", ena, 0);
                  end else begin
                     chk("done_time", cyc, ref_cyc + t.gap);
                  end
               end
            end
         end
         ena_prev = ena;
      end
   end

   task automatic chk_reset_vals(input string nm);
      chk(nm, {busy, done, err, rd_valid, ena, sel,
               address, data, rd_addr, rd_data},
          {5'b0, 1'b1, 32'h0});
   endtask

   task automatic run(input int s, input bit hng,
                      input bit poke_busy, input bit poke_done);
      bit fin;
      fin = 0;
      hang = hng;
      model(s, hng);
      @(negedge clk);
      start_idx = 6'(s);
      start = 1'b1;
      ref_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < 3000 && !fin; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke_busy && k == 3) begin
            start_idx = 6'd0;
            start = 1'b1;
         end
         if (done || err) fin = 1;
      end
      start = 1'b0;
      chk("run_end_seen", fin, 1);
      if (poke_done) begin
         start_idx = 6'd0;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      repeat (4) @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("op_q_drained", op_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("end_q_drained", end_q.size(), 0);
   endtask

   initial begin : seq
      int scr[6];
      scr = '{0, 2, 4, 10, 16, 60};
      for (int i = 0; i < DEPTH; i++) tbl[i] = IMG[18*i +: 18];
      rst = 1'b1;
      start = 1'b0;
      start_idx = 6'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset_state");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      fixed_lat = 1;
      run(0, 0, 0, 0);
      fixed_lat = 0;
      run(2, 0, 0, 0);
      run(4, 0, 0, 0);
      run(8, 1, 0, 0);
      run(0, 0, 0, 0);
      run(60, 0, 1, 0);
      run(0, 0, 0, 1);

      model(10, 1);
      hang = 1;
      @(negedge clk);
      start_idx = 6'd10;
      start = 1'b1;
      ref_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("ena_before_rst", ena, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("reset_mid_wait");
      rst = 1'b0;
      op_q.delete();
      end_q.delete();
      hang = 0;
      repeat (2) @(negedge clk);
      run(10, 0, 0, 0);

      for (int n = 0; n < 12; n++) run(scr[$urandom_range(0, 5)], 0, 0, 0);

      chk("resp_q_drained", resp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
